// File: rtl/lsu_wb_if.sv
// Wishbone classic single-cycle master/slave bundle between the LSU and the word RAM.
interface lsu_wb_if #(
    parameter int unsigned ADDR_W = 30
);
    logic              wb_cyc;
    logic              wb_stb;
    logic              wb_we;
    logic [ADDR_W-1:0] wb_adr;
    logic [31:0]       wb_dat_w;
    logic [31:0]       wb_dat_r;
    logic              wb_ack;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
        input  wb_dat_r, wb_ack
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_w,
        output wb_dat_r, wb_ack
    );
endinterface

// File: rtl/lsu_wb.sv
// Load/store unit: one Wishbone cycle per core request, with lane extraction on loads
// and read-modify-write for byte/halfword stores (the RAM has no byte selects).
module lsu_wb #(
    parameter int unsigned ADDR_W = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy,
    lsu_wb_if.master    bus
);
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MERGE,
        S_WR,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        lane_q, lane_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [31:0]       rd_q, rd_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              cyc_q, cyc_d;
    logic              stb_q, stb_d;
    logic              wb_we_q, wb_we_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [31:0]       dat_w_q, dat_w_d;

    logic              illegal_c;
    logic              misalign_c;
    logic [31:0]       shifted_c;
    logic [31:0]       load_c;
    logic [31:0]       mask_c;
    logic [31:0]       lane_data_c;
    logic [31:0]       merged_c;

    // Request legality, evaluated on the raw inputs in the accepting cycle
    always_comb begin
        illegal_c  = 1'b0;
        misalign_c = 1'b0;
        if (we) begin
            illegal_c = !(funct3 inside {F3_B, F3_H, F3_W});
        end else begin
            illegal_c = funct3 inside {3'b011, 3'b110, 3'b111};
        end
        misalign_c = ((funct3[1:0] == 2'b01) && addr[0]) ||
                     ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    // Load lane extraction and sign/zero extension from the live read data
    always_comb begin
        shifted_c = bus.wb_dat_r >> {lane_q, 3'b000};
        case (funct3_q)
            F3_B:    load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            F3_BU:   load_c = {24'h0, shifted_c[7:0]};
            F3_H:    load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            F3_HU:   load_c = {16'h0, shifted_c[15:0]};
            default: load_c = bus.wb_dat_r;
        endcase
    end

    // Sub-word store merge into the captured read word
    always_comb begin
        mask_c      = (funct3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {lane_q, 3'b000};
        lane_data_c = funct3_q[0] ? {2{wdata_q}} : {4{wdata_q[7:0]}};
        merged_c    = (rd_q & ~mask_c) | (lane_data_c & mask_c);
    end

    // Next state and registered-output precompute
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        rd_d     = rd_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        adr_d    = adr_q;
        dat_w_d  = dat_w_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d     = we;
                    funct3_d = funct3;
                    lane_d   = addr[1:0];
                    wdata_d  = wdata[15:0];
                    adr_d    = addr[ADDR_W+1:2];
                    if (illegal_c || misalign_c) begin
                        state_d = S_RESP;
                        err_d   = 1'b1;
                        rdata_d = 32'h0;
                    end else if (we && (funct3 == F3_W)) begin
                        state_d = S_WR;
                        dat_w_d = wdata;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                if (bus.wb_ack) begin
                    rd_d = bus.wb_dat_r;
                    if (we_q) begin
                        state_d = S_MERGE;
                    end else begin
                        state_d = S_RESP;
                        err_d   = 1'b0;
                        rdata_d = load_c;
                    end
                end
            end
            S_MERGE: begin
                dat_w_d = merged_c;
                state_d = S_WR;
            end
            S_WR: begin
                if (bus.wb_ack) begin
                    state_d = S_RESP;
                    err_d   = 1'b0;
                    rdata_d = 32'h0;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d  = (state_d == S_RESP);
        busy_d  = (state_d != S_IDLE);
        cyc_d   = state_d inside {S_RD, S_MERGE, S_WR};
        stb_d   = state_d inside {S_RD, S_WR};
        wb_we_d = (state_d == S_WR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'h0;
            lane_q   <= 2'h0;
            wdata_q  <= 16'h0;
            rd_q     <= 32'h0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
            busy_q   <= 1'b0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            wb_we_q  <= 1'b0;
            adr_q    <= '0;
            dat_w_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            rd_q     <= rd_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            wb_we_q  <= wb_we_d;
            adr_q    <= adr_d;
            dat_w_q  <= dat_w_d;
        end
    end

    assign done         = done_q;
    assign err          = err_q;
    assign rdata        = rdata_q;
    assign busy         = busy_q;
    assign bus.wb_cyc   = cyc_q;
    assign bus.wb_stb   = stb_q;
    assign bus.wb_we    = wb_we_q;
    assign bus.wb_adr   = adr_q;
    assign bus.wb_dat_w = dat_w_q;

endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: registered-ACK RAM slave model plus a done-time scoreboard.
module tb_lsu_wb;
    localparam int unsigned ADDR_W = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        busy;

    always #5 clk = ~clk;

    lsu_wb_if #(.ADDR_W(ADDR_W)) bus ();

    lsu_wb #(.ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .done   (done),
        .err    (err),
        .rdata  (rdata),
        .busy   (busy),
        .bus    (bus)
    );

    // RAM slave: one-cycle registered ACK, masked with CYC; stray_ack injects a bogus ACK
    logic [31:0] mem [64];
    logic        ack_q;
    logic [31:0] rdat_q;
    logic        stray_ack = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q <= 1'b0;
        end else begin
            ack_q <= bus.wb_cyc & bus.wb_stb & ~ack_q;
            if (bus.wb_cyc && bus.wb_stb && !ack_q) begin
                if (bus.wb_we) mem[bus.wb_adr[5:0]] <= bus.wb_dat_w;
                else           rdat_q <= mem[bus.wb_adr[5:0]];
            end
        end
    end

    assign bus.wb_ack   = (ack_q & bus.wb_cyc) | stray_ack;
    assign bus.wb_dat_r = rdat_q;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int merge_cnt = 0;
    int bus_cyc_cnt = 0;
    logic [31:0] last_wdat = 32'h0;
    logic [31:0] last_adr = 32'h0;

    string       exp_tag_q[$];
    logic [31:0] exp_rdata_q[$];
    logic        exp_err_q[$];
    int          exp_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Bus activity monitor and scoreboard pop on done
    always @(negedge clk) begin
        if (rst) begin
            if (bus.wb_cyc && !bus.wb_stb) merge_cnt <= merge_cnt + 1;
            if (bus.wb_cyc) bus_cyc_cnt <= bus_cyc_cnt + 1;
            if (bus.wb_cyc && bus.wb_stb && bus.wb_we) last_wdat <= bus.wb_dat_w;
            if (bus.wb_cyc && bus.wb_stb) last_adr <= 32'(bus.wb_adr);
            if (done) begin
                if (exp_tag_q.size() == 0) begin
                    chk("spurious_done", 32'd1, 32'd0);
                end else begin
                    chk({exp_tag_q[0], "_rdata"}, rdata, exp_rdata_q[0]);
                    chk({exp_tag_q[0], "_err"}, 32'(err), 32'(exp_err_q[0]));
                    chk({exp_tag_q[0], "_cycle"}, 32'(cyc_cnt), 32'(exp_cyc_q[0]));
                    void'(exp_tag_q.pop_front());
                    void'(exp_rdata_q.pop_front());
                    void'(exp_err_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    task automatic push_exp(input string tag, input logic [31:0] er, input logic ee, input int lat);
        exp_tag_q.push_back(tag);
        exp_rdata_q.push_back(er);
        exp_err_q.push_back(ee);
        exp_cyc_q.push_back(cyc_cnt + lat);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40 && exp_tag_q.size() != 0; i++) @(negedge clk);
        if (exp_tag_q.size() != 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            exp_tag_q.delete();
            exp_rdata_q.delete();
            exp_err_q.delete();
            exp_cyc_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic do_op(input string tag, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input int lat);
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd;
        push_exp(tag, er, ee, lat);
        @(negedge clk);
        req = 1'b0;
        wait_idle(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int m0;
        int c0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cyc", 32'(bus.wb_cyc), 32'd0);
        chk("rst_stb", 32'(bus.wb_stb), 32'd0);
        chk("rst_we", 32'(bus.wb_we), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_adr", 32'(bus.wb_adr), 32'h0);
        chk("rst_datw", bus.wb_dat_w, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // word round trip
        do_op("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
        do_op("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
        chk("lw10_adr", last_adr, 32'h4);
        chk("lw10_hold", rdata, 32'hDEAD_BEEF);

        // signed / unsigned sub-word loads
        do_op("sw20", 1'b1, 3'b010, 32'h20, 32'h80FF_7F01, 32'h0, 1'b0, 3);
        do_op("lb23", 1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFF_FF80, 1'b0, 3);
        do_op("lbu23", 1'b0, 3'b100, 32'h23, 32'h0, 32'h0000_0080, 1'b0, 3);
        do_op("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_80FF, 1'b0, 3);
        do_op("lhu20", 1'b0, 3'b101, 32'h20, 32'h0, 32'h0000_7F01, 1'b0, 3);
        do_op("lbu21", 1'b0, 3'b100, 32'h21, 32'h0, 32'h0000_007F, 1'b0, 3);

        // read-modify-write stores
        do_op("sw20b", 1'b1, 3'b010, 32'h20, 32'h1122_3344, 32'h0, 1'b0, 3);
        m0 = merge_cnt;
        do_op("sb21", 1'b1, 3'b000, 32'h21, 32'h0000_00AA, 32'h0, 1'b0, 6);
        chk("sb21_merge_cycles", 32'(merge_cnt - m0), 32'd1);
        chk("sb21_datw", last_wdat, 32'h1122_AA44);
        do_op("sh22", 1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'h0, 1'b0, 6);
        chk("sh22_datw", last_wdat, 32'hBEEF_AA44);
        do_op("lw20", 1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEF_AA44, 1'b0, 3);

        // errors issue no bus cycle and leave memory alone
        do_op("sw00", 1'b1, 3'b010, 32'h00, 32'h0BAD_F00D, 32'h0, 1'b0, 3);
        c0 = bus_cyc_cnt;
        do_op("lw06", 1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1, 1);
        do_op("sh03", 1'b1, 3'b001, 32'h03, 32'hFFFF, 32'h0, 1'b1, 1);
        do_op("ld011", 1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1);
        do_op("st100", 1'b1, 3'b100, 32'h00, 32'h5555_5555, 32'h0, 1'b1, 1);
        chk("err_no_cyc", 32'(bus_cyc_cnt - c0), 32'd0);
        do_op("lw00", 1'b0, 3'b010, 32'h00, 32'h0, 32'h0BAD_F00D, 1'b0, 3);

        // stray ACK in IDLE is ignored
        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        chk("stray_busy", 32'(busy), 32'd0);
        @(negedge clk);

        // request pulsed while busy is dropped
        do_op("sw40", 1'b1, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 3);
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h40; wdata = 32'h0;
        push_exp("lw40", 32'h0, 1'b0, 3);
        @(negedge clk);
        we = 1'b1; wdata = 32'h1234_5678;
        @(negedge clk);
        req = 1'b0;
        wait_idle("lw40");
        do_op("lw40b", 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 3);

        // back-to-back with req held high
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
        push_exp("b2b_1", 32'hDEAD_BEEF, 1'b0, 3);
        push_exp("b2b_2", 32'hDEAD_BEEF, 1'b0, 7);
        repeat (5) @(negedge clk);
        req = 1'b0;
        wait_idle("b2b");

        // reset during the write phase of SB abandons it
        do_op("sw30", 1'b1, 3'b010, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, 3);
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b000; addr = 32'h31; wdata = 32'h55;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 10 && !(bus.wb_cyc && bus.wb_stb && bus.wb_we); i++) @(negedge clk);
        chk("sb31_reached_wr", 32'(bus.wb_cyc && bus.wb_stb && bus.wb_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid_rst_cyc", 32'(bus.wb_cyc), 32'd0);
        chk("mid_rst_stb", 32'(bus.wb_stb), 32'd0);
        chk("mid_rst_we", 32'(bus.wb_we), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_op("lw30", 1'b0, 3'b010, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, 3);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lsu_wb.md
Name: lsu_wb

Overview:
- Load/store unit that turns core memory requests into single Wishbone master cycles against the word-addressed 32-bit RAM slave.
- It handles byte and halfword access: lane extraction and sign/zero extension on loads, and read-modify-write on sub-word stores, because the RAM has no byte selects.
- It sits between the core execute stage and the Wishbone RAM slave.
- It flags misaligned and illegal-width accesses without issuing any bus cycle.

Parameters:
ADDR_W, 30, width of wb_adr word address; wb_adr = addr[ADDR_W+1:2]

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
req  in  1  request strobe; sampled only in IDLE
we  in  1  1 = store, 0 = load
funct3  in  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  byte address
wdata  in  32  store data, right-aligned
done  out  1  one-cycle completion pulse
err  out  1  valid with done; misaligned or illegal funct3
rdata  out  32  load result, valid with done; held until next done
busy  out  1  high in any state other than IDLE
wb_cyc  out  1  Wishbone CYC
wb_stb  out  1  Wishbone STB
wb_we  out  1  Wishbone WE
wb_adr  out  ADDR_W  word address
wb_dat_w  out  32  write data to slave
wb_dat_r  in  32  read data from slave, valid when wb_ack=1
wb_ack  in  1  Wishbone ACK (slave masks it with CYC)

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. done, err, busy, wb_cyc, wb_stb and wb_we are 0. rdata, wb_adr and wb_dat_w are 0.
- Reset mid-transaction: bus signals drop immediately, no done is produced, and any partial read-modify-write is abandoned.
- Accepting a request: in IDLE with req=1, latch we, funct3, addr and wdata, then check the request.
  - Illegal funct3: for loads 011/110/111; for stores anything other than 000/001/010.
  - Misaligned: H/HU with addr[0]=1, or W with addr[1:0]≠0.
  - Either case goes to RESP with err=1 and issues no bus cycle.
- Bus outputs decode from the registered state. wb_cyc=1 in RD, MERGE and WR; wb_stb=1 in RD and WR only; wb_we=1 in WR only.
- States and transitions:
  - IDLE: legal load or SB/SH → RD; SW → WR with wb_dat_w=wdata; error → RESP.
  - RD: wait for wb_ack. On ack, capture wb_dat_r. A load then goes to RESP; SB/SH goes to MERGE.
  - MERGE: CYC=1, STB=0 for exactly one cycle. This clears the slave's registered ACK before the write. ACK seen in this state is ignored. Build the merged word, then go to WR.
  - WR: wait for wb_ack → RESP.
  - RESP: done=1 for one cycle with err/rdata valid, then → IDLE. Bus signals are 0.
- Lane rules (lane = addr[1:0]):
  - LB/LBU take bits [8*lane+7 : 8*lane]. LH/LHU take the half selected by addr[1] at [16*h+15 : 16*h].
  - LB/LH sign-extend; BU/HU zero-extend.
  - SB replaces byte lane with wdata[7:0]; SH replaces half h with wdata[15:0]; all other bits keep the read value.
- rdata is 0 on stores and on err.
- Latency from the req cycle to the done cycle: LB/LH/LW/SW = 3 cycles; SB/SH = 6 cycles; error = 1 cycle.
- Minimum IDLE-to-IDLE gap: req is ignored while busy, so requests asserted outside IDLE are dropped, not queued.
- Held req: if req stays high, a new transaction starts in the IDLE cycle after RESP.
- Stray wb_ack in IDLE or RESP is ignored.
- There is no ACK timeout; the FSM waits indefinitely in RD or WR.

Test Plan:
- Word round trip: SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 → wb_adr=4; done at +3 on each; rdata=0xDEADBEEF, err=0.
- Signed and unsigned loads: word 0x80FF7F01 at 0x20.
  - LB 0x23 → 0xFFFFFF80; LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80FF; LHU 0x20 → 0x00007F01.
- Byte/halfword stores:
  - SB 0x21 wdata 0xAA on 0x11223344 → RD, MERGE (STB=0 one cycle), WR with wb_dat_w=0x1122AA44; done at +6.
  - SH 0x22 wdata 0xBEEF → 0xBEEFAA44.
- Errors: LW 0x06, SH 0x03 and funct3=011 load → err=1, done at +1, wb_cyc never asserted, memory unchanged.
- Reset mid-operation: assert rst=0 during WR of SB → bus signals 0 immediately, done never pulses. After release, LW of that word returns its pre-SB value.
- Back-to-back with req held high: two LWs complete with done pulses 4 cycles apart; req pulsed during busy is dropped.
